// File: rtl/wb_write_queue_if.sv
// Writeback queue bus: load/ALU producer handshakes, register-file write port,
// forwarding lookups and occupancy.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            ld_valid;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            reg_wr;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   fwd_addr1;
    logic [AW-1:0]   fwd_addr2;
    logic            fwd_hit1;
    logic [XLEN-1:0] fwd_data1;
    logic            fwd_hit2;
    logic [XLEN-1:0] fwd_data2;
    logic [CW-1:0]   count;

    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
               fwd_addr1, fwd_addr2,
        output ld_ready, alu_ready, reg_wr, waddr, wdata,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );

    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data,
               fwd_addr1, fwd_addr2,
        input  ld_ready, alu_ready, reg_wr, waddr, wdata,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback FIFO draining one entry per cycle into the register file.
// Youngest-match forwarding of queued writes is built only when WBQ_FWD_EN is defined.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    wb_write_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]   r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic [CW-1:0]   w_free;
    logic            w_ld_push;
    logic            w_alu_push;
    logic            w_pop;
    logic [PW-1:0]   w_alu_slot;

    // Space is judged before this cycle's pop, so a full queue never accepts.
    assign w_free        = CW'(DEPTH) - r_count;
    assign bus.ld_ready  = reset && (w_free >= CW'(1));
    assign bus.alu_ready = reset && (w_free >= (bus.ld_valid ? CW'(2) : CW'(1)));

    // rd==0 completes the handshake but is never stored.
    assign w_ld_push  = bus.ld_valid  && bus.ld_ready  && (bus.ld_rd  != '0);
    assign w_alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
    assign w_pop      = (r_count != '0);
    assign w_alu_slot = r_wr_ptr + PW'(w_ld_push);

    assign bus.reg_wr = w_pop;
    assign bus.waddr  = w_pop ? r_rd[r_rd_ptr]   : '0;
    assign bus.wdata  = w_pop ? r_data[r_rd_ptr] : '0;
    assign bus.count  = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_ld_push) begin
                r_rd[r_wr_ptr]   <= bus.ld_rd;
                r_data[r_wr_ptr] <= bus.ld_data;
            end
            if (w_alu_push) begin
                r_rd[w_alu_slot]   <= bus.alu_rd;
                r_data[w_alu_slot] <= bus.alu_data;
            end
            r_wr_ptr <= r_wr_ptr + PW'(w_ld_push) + PW'(w_alu_push);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_ld_push) + CW'(w_alu_push) - CW'(w_pop);
        end
    end

`ifdef WBQ_FWD_EN
    logic [PW-1:0] w_age_idx [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign w_age_idx[g] = r_rd_ptr + PW'(g);
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        bus.fwd_hit1  = 1'b0;
        bus.fwd_data1 = '0;
        bus.fwd_hit2  = 1'b0;
        bus.fwd_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < r_count) begin
                if ((bus.fwd_addr1 != '0) && (r_rd[w_age_idx[k]] == bus.fwd_addr1)) begin
                    bus.fwd_hit1  = 1'b1;
                    bus.fwd_data1 = r_data[w_age_idx[k]];
                end
                if ((bus.fwd_addr2 != '0) && (r_rd[w_age_idx[k]] == bus.fwd_addr2)) begin
                    bus.fwd_hit2  = 1'b1;
                    bus.fwd_data2 = r_data[w_age_idx[k]];
                end
            end
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd  = ^{bus.fwd_addr1, bus.fwd_addr2};
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_data1 = '0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data2 = '0;
`endif
endmodule
